// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the clock-gate sequencer.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    IDLE = 2'd3
  } state_e;

  localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Requester/ICG-side signal bundle for the clock-gate sequencer.
interface clk_gate_ctrl_if
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned NumReq = 4
);

  logic [NumReq-1:0] req_i;
  logic [NumReq-1:0] ack_o;
  logic              busy_i;
  logic              test_mode_i;
  logic              gate_en_o;
  state_e            state_o;

  modport slave (
    input  req_i, busy_i, test_mode_i,
    output ack_o, gate_en_o, state_o
  );

  modport master (
    output req_i, busy_i, test_mode_i,
    input  ack_o, gate_en_o, state_o
  );

endinterface

// File: rtl/clk_gate_ctrl_timer.sv
// Loadable down-counter shared by the wake and idle phases; stops at zero.
module clk_gate_ctrl_timer #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Sequencer for a downstream ICG: wake delay, ack handshake, idle-timeout shutdown.
// Optional wake-event statistics counter enabled by CLK_GATE_CTRL_STATS_EN.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned NumReq     = 4,
  parameter int unsigned WakeCycles = 2,
  parameter int unsigned IdleCycles = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
`ifdef CLK_GATE_CTRL_STATS_EN
  input  logic               clr_stats_i,
  output logic [STATS_W-1:0] wake_cnt_o,
`endif
  clk_gate_ctrl_if.slave     bus
);

  localparam int unsigned MaxCycles = (WakeCycles > IdleCycles) ? WakeCycles : IdleCycles;
  localparam int unsigned CntWidth  = $clog2((MaxCycles > 1) ? MaxCycles : 1) + 1;
  localparam logic [CntWidth-1:0] WakeLoad =
    (WakeCycles == 0) ? '0 : CntWidth'(WakeCycles - 1);
  localparam logic [CntWidth-1:0] IdleLoad =
    (IdleCycles == 0) ? '0 : CntWidth'(IdleCycles - 1);

  state_e              state_q, state_d;
  logic                any_act;
  logic                tmr_load;
  logic                tmr_dec;
  logic [CntWidth-1:0] tmr_val;
  logic                tmr_zero;

  assign any_act = (|bus.req_i) | bus.busy_i;

  clk_gate_ctrl_timer #(
    .Width (CntWidth)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero)
  );

  // Next-state logic; a live request always beats timer expiry.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      OFF: begin
        if (any_act) begin
          if (WakeCycles == 0) begin
            state_d = ON;
          end else begin
            state_d  = WAKE;
            tmr_load = 1'b1;
            tmr_val  = WakeLoad;
          end
        end
      end
      WAKE: begin
        if (tmr_zero) begin
          state_d = ON;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ON: begin
        if (!any_act) begin
          if (IdleCycles == 0) begin
            state_d = OFF;
          end else begin
            state_d  = IDLE;
            tmr_load = 1'b1;
            tmr_val  = IdleLoad;
          end
        end
      end
      IDLE: begin
        if (any_act) begin
          state_d = ON;
        end else if (tmr_zero) begin
          state_d = OFF;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Enable is Moore on the state register so it never glitches with req.
  assign bus.gate_en_o = (state_q != OFF) | bus.test_mode_i;
  assign bus.ack_o     = bus.req_i & {NumReq{state_q == ON}};
  assign bus.state_o   = state_q;

`ifdef CLK_GATE_CTRL_STATS_EN
  logic [STATS_W-1:0] wake_cnt_q, wake_cnt_d;
  logic               wake_evt;

  assign wake_evt = (state_q == OFF) && (state_d != OFF);

  always_comb begin
    wake_cnt_d = wake_cnt_q;
    if (clr_stats_i) begin
      wake_cnt_d = '0;
    end else if (wake_evt && (wake_cnt_q != '1)) begin
      wake_cnt_d = wake_cnt_q + STATS_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wake_cnt_q <= '0;
    end else begin
      wake_cnt_q <= wake_cnt_d;
    end
  end

  assign wake_cnt_o = wake_cnt_q;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: default-parameter and zero-delay instances.
// Stats checks are compiled in when CLK_GATE_CTRL_STATS_EN is defined.
module tb_clk_gate_ctrl;
  import clk_gate_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  clk_gate_ctrl_if #(.NumReq(4)) bus_a ();
  clk_gate_ctrl_if #(.NumReq(4)) bus_b ();

`ifdef CLK_GATE_CTRL_STATS_EN
  logic               clr_a, clr_b;
  logic [STATS_W-1:0] wcnt_a, wcnt_b;
`endif

  clk_gate_ctrl #(.NumReq(4), .WakeCycles(2), .IdleCycles(16)) dut_a (
    .clk_i       (clk),
    .rst_i       (rst),
`ifdef CLK_GATE_CTRL_STATS_EN
    .clr_stats_i (clr_a),
    .wake_cnt_o  (wcnt_a),
`endif
    .bus         (bus_a)
  );

  clk_gate_ctrl #(.NumReq(4), .WakeCycles(0), .IdleCycles(0)) dut_b (
    .clk_i       (clk),
    .rst_i       (rst),
`ifdef CLK_GATE_CTRL_STATS_EN
    .clr_stats_i (clr_b),
    .wake_cnt_o  (wcnt_b),
`endif
    .bus         (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic dropped;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus_a.req_i = '0; bus_a.busy_i = 1'b0; bus_a.test_mode_i = 1'b0;
    bus_b.req_i = '0; bus_b.busy_i = 1'b0; bus_b.test_mode_i = 1'b0;
`ifdef CLK_GATE_CTRL_STATS_EN
    clr_a = 1'b0; clr_b = 1'b0;
`endif
    tick(2);
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(bus_a.state_o), 32'(OFF));
    chk("rst_gate",  32'(bus_a.gate_en_o), 32'd0);
    chk("rst_ack",   32'(bus_a.ack_o), 32'd0);

    // Wake: req at cycle 0, gate at 1, ack at 3
    bus_a.req_i = 4'b0001;
    #1;
    chk("wake_c0_ack", 32'(bus_a.ack_o), 32'd0);
    tick();
    chk("wake_c1_gate",  32'(bus_a.gate_en_o), 32'd1);
    chk("wake_c1_state", 32'(bus_a.state_o), 32'(WAKE));
    tick();
    chk("wake_c2_ack",   32'(bus_a.ack_o), 32'd0);
    tick();
    chk("wake_c3_ack",   32'(bus_a.ack_o), 32'b0001);
    chk("wake_c3_state", 32'(bus_a.state_o), 32'(ON));

    // Idle: release at t, gate low at t+17
    tick(2);
    bus_a.req_i = 4'b0000;
    #1;
    chk("idle_t_ack", 32'(bus_a.ack_o), 32'd0);
    tick(16);
    chk("idle_t16_gate",  32'(bus_a.gate_en_o), 32'd1);
    chk("idle_t16_state", 32'(bus_a.state_o), 32'(IDLE));
    tick();
    chk("idle_t17_gate",  32'(bus_a.gate_en_o), 32'd0);
    chk("idle_t17_state", 32'(bus_a.state_o), 32'(OFF));

    // Rescue: new request exactly when idle timer reaches zero
    bus_a.req_i = 4'b0001;
    tick(3);
    chk("resc_on", 32'(bus_a.state_o), 32'(ON));
    bus_a.req_i = 4'b0000;
    dropped = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!bus_a.gate_en_o) dropped = 1'b1;
    end
    chk("resc_idle_state", 32'(bus_a.state_o), 32'(IDLE));
    bus_a.req_i = 4'b0100;
    #1;
    chk("resc_idle_ack", 32'(bus_a.ack_o), 32'd0);
    tick();
    if (!bus_a.gate_en_o) dropped = 1'b1;
    chk("resc_state", 32'(bus_a.state_o), 32'(ON));
    chk("resc_ack",   32'(bus_a.ack_o), 32'b0100);
    chk("resc_gate_held", 32'(dropped), 32'd0);
    bus_a.req_i = 4'b0000;
    tick(17);
    chk("resc_off", 32'(bus_a.state_o), 32'(OFF));

    // Busy holds clock on without ack
    bus_a.busy_i = 1'b1;
    tick();
    chk("busy_gate",  32'(bus_a.gate_en_o), 32'd1);
    chk("busy_state", 32'(bus_a.state_o), 32'(WAKE));
    tick(6);
    chk("busy_on_state", 32'(bus_a.state_o), 32'(ON));
    chk("busy_ack",      32'(bus_a.ack_o), 32'd0);
    bus_a.busy_i = 1'b0;
    tick(16);
    chk("busy_idle_gate", 32'(bus_a.gate_en_o), 32'd1);
    tick();
    chk("busy_off_gate", 32'(bus_a.gate_en_o), 32'd0);

    // Test mode forces enable only
    bus_a.test_mode_i = 1'b1;
    #1;
    chk("tm_gate", 32'(bus_a.gate_en_o), 32'd1);
    tick();
    chk("tm_state", 32'(bus_a.state_o), 32'(OFF));
    bus_a.test_mode_i = 1'b0;
    #1;
    chk("tm_off_gate", 32'(bus_a.gate_en_o), 32'd0);

    // Zero-delay instance: ack 1 cycle after req, gate low 1 cycle after drop
    for (int k = 0; k < 3; k++) begin
      bus_b.req_i = 4'b0010;
      #1;
      chk("z_c0_ack", 32'(bus_b.ack_o), 32'd0);
      tick();
      chk("z_c1_ack",  32'(bus_b.ack_o), 32'b0010);
      chk("z_c1_gate", 32'(bus_b.gate_en_o), 32'd1);
      bus_b.req_i = 4'b0000;
      #1;
      chk("z_drop_ack", 32'(bus_b.ack_o), 32'd0);
      tick();
      chk("z_off_gate",  32'(bus_b.gate_en_o), 32'd0);
      chk("z_off_state", 32'(bus_b.state_o), 32'(OFF));
    end

`ifdef CLK_GATE_CTRL_STATS_EN
    chk("stats_b_cnt", 32'(wcnt_b), 32'd3);
    chk("stats_a_cnt", 32'(wcnt_a), 32'd3);
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    chk("stats_b_clr", 32'(wcnt_b), 32'd0);
    chk("stats_a_kept", 32'(wcnt_a), 32'd3);
`endif

    // Async reset mid-WAKE, checked before any further clock edge
    bus_a.req_i = 4'b0001;
    tick();
    chk("pre_rst_state", 32'(bus_a.state_o), 32'(WAKE));
    rst = 1'b1;
    #1;
    chk("arst_gate",  32'(bus_a.gate_en_o), 32'd0);
    chk("arst_ack",   32'(bus_a.ack_o), 32'd0);
    chk("arst_state", 32'(bus_a.state_o), 32'(OFF));
    bus_a.req_i = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_state", 32'(bus_a.state_o), 32'(OFF));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
